// File: rtl/multi_edge_detector_pkg.sv
// Shared types for the multi-channel edge detector: FSM state encoding,
// tick-mode encoding and small helpers used by the channel and top level.
package edge_det_pkg;

   typedef enum logic [1:0] {
      LOW  = 2'b00,
      RISE = 2'b01,
      HIGH = 2'b10,
      FALL = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      MODE_RISE = 2'b00,
      MODE_FALL = 2'b01,
      MODE_BOTH = 2'b10,
      MODE_OFF  = 2'b11
   } mode_t;

   function automatic logic rise_enabled(input mode_t m);
      return (m == MODE_RISE) || (m == MODE_BOTH);
   endfunction

   function automatic logic fall_enabled(input mode_t m);
      return (m == MODE_FALL) || (m == MODE_BOTH);
   endfunction

   // Filter counter width; a filter length of 1 still needs one bit.
   function automatic int cnt_width(input int filter_len);
      return (filter_len > 1) ? $clog2(filter_len) : 1;
   endfunction

endpackage

// File: rtl/multi_edge_detector_if.sv
// Signal bundle between the edge detector and its user: raw levels, mode
// and clears in; ticks, sticky pending flags and interrupt out.
interface multi_edge_detector_if #(
   parameter int N = 4
);
   logic [N-1:0] level;
   logic [1:0]   mode;
   logic [N-1:0] clr;
   logic [N-1:0] rise_tick;
   logic [N-1:0] fall_tick;
   logic [N-1:0] pending;
   logic         irq;

   modport master (
      output level, mode, clr,
      input  rise_tick, fall_tick, pending, irq
   );

   modport slave (
      input  level, mode, clr,
      output rise_tick, fall_tick, pending, irq
   );
endinterface

// File: rtl/multi_edge_detector_channel.sv
// One channel: synchroniser chain, glitch-filter counter and four-state
// Moore FSM producing mode-masked rise/fall ticks.
module edge_det_channel
   import edge_det_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic  clk,
   input  logic  reset_n,
   input  logic  level,
   input  mode_t mode_q,
   output logic  rise_tick,
   output logic  fall_tick
);
   localparam int CNT_W = cnt_width(FILTER_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [SYNC_STAGES-1:0] sync_next;
   logic                   s;

   state_t                 state_reg;
   state_t                 state_next;
   logic [CNT_W-1:0]       cnt_reg;
   logic [CNT_W-1:0]       cnt_next;

   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : gen_sync
         if (gi == 0) begin : g_first
            assign sync_next[gi] = level;
         end else begin : g_rest
            assign sync_next[gi] = sync_reg[gi-1];
         end
      end
   endgenerate

   assign s = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_reg  <= '0;
         state_reg <= LOW;
         cnt_reg   <= '0;
      end else begin
         sync_reg  <= sync_next;
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // The counter measures consecutive samples that disagree with the
   // settled level; any agreeing sample restarts the qualification.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         LOW: begin
            if (!s) begin
               cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = RISE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         HIGH: begin
            if (s) begin
               cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = FALL;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         RISE: begin
            state_next = HIGH;
            cnt_next   = '0;
         end
         FALL: begin
            state_next = LOW;
            cnt_next   = '0;
         end
         default: begin
            state_next = LOW;
            cnt_next   = '0;
         end
      endcase
   end

   // Mode only masks the ticks; the FSM keeps tracking regardless.
   always_comb begin
      rise_tick = (state_reg == RISE) && rise_enabled(mode_q);
      fall_tick = (state_reg == FALL) && fall_enabled(mode_q);
   end

endmodule

// File: rtl/multi_edge_detector.sv
// Top level: registered mode, N independent edge-detect channels, sticky
// per-channel pending flags and their OR as interrupt.
module multi_edge_detector
   import edge_det_pkg::*;
#(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   multi_edge_detector_if.slave  bus
);
   mode_t        mode_q;
   logic [N-1:0] rise_vec;
   logic [N-1:0] fall_vec;
   logic [N-1:0] pending_reg;
   logic [N-1:0] pending_next;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mode_q <= MODE_RISE;
      end else begin
         mode_q <= mode_t'(bus.mode);
      end
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : gen_ch
         edge_det_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
         ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .level     (bus.level[gi]),
            .mode_q    (mode_q),
            .rise_tick (rise_vec[gi]),
            .fall_tick (fall_vec[gi])
         );
      end
   endgenerate

   // A tick arriving together with a clear keeps the flag set.
   assign pending_next = (pending_reg & ~bus.clr) | rise_vec | fall_vec;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   assign bus.rise_tick = rise_vec;
   assign bus.fall_tick = fall_vec;
   assign bus.pending   = pending_reg;
   assign bus.irq       = |pending_reg;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector with default parameters
// (N=4, SYNC_STAGES=2, FILTER_LEN=3: tick seen on the 5th edge).
module tb_multi_edge_detector;
   import edge_det_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;

   int exp_rises [4] = '{1, 0, 1, 0};
   int exp_falls [4] = '{0, 1, 1, 0};

   multi_edge_detector_if #(.N(N)) bus ();

   multi_edge_detector #(
      .N           (N),
      .SYNC_STAGES (2),
      .FILTER_LEN  (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end else begin
         $display("ok   %s = 0x%0h", tag, observed);
      end
   endtask

   // Advance one clock; outputs are then sampled mid-cycle.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic watch(input int cycles, input int ch,
                        output int rises, output int falls,
                        output int first_rise, output int first_fall);
      rises = 0; falls = 0; first_rise = -1; first_fall = -1;
      for (int c = 1; c <= cycles; c++) begin
         step();
         if (bus.rise_tick[ch]) begin
            rises++;
            if (first_rise < 0) first_rise = c;
         end
         if (bus.fall_tick[ch]) begin
            falls++;
            if (first_fall < 0) first_fall = c;
         end
      end
   endtask

   initial begin
      int r, f, fr, ff, r2, f2, fr2, ff2, r3, f3, fr3, ff3;

      // Reset with all inputs high, then full-latency rise on all channels
      reset_n   = 1'b0;
      bus.level = 4'hF;
      bus.mode  = MODE_RISE;
      bus.clr   = 4'h0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) step();
      check("reset_rise", 32'(bus.rise_tick), 32'h0);
      check("reset_fall", 32'(bus.fall_tick), 32'h0);
      check("reset_pending", 32'(bus.pending), 32'h0);
      check("reset_irq", 32'(bus.irq), 32'h0);
      reset_n = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
         check($sformatf("rst_quiet_rise_c%0d", c), 32'(bus.rise_tick), 32'h0);
         check($sformatf("rst_quiet_irq_c%0d", c), 32'(bus.irq), 32'h0);
      end
      step();
      check("rst_release_rise", 32'(bus.rise_tick), 32'hF);
      check("rst_release_pending_early", 32'(bus.pending), 32'h0);
      step();
      check("rst_release_rise_gone", 32'(bus.rise_tick), 32'h0);
      check("rst_release_pending", 32'(bus.pending), 32'hF);
      check("rst_release_irq", 32'(bus.irq), 32'h1);
      bus.clr = 4'hF;
      step();
      bus.clr = 4'h0;
      check("clr_all_pending", 32'(bus.pending), 32'h0);
      check("clr_all_irq", 32'(bus.irq), 32'h0);

      // Falling edges masked in rise-only mode
      bus.level = 4'h0;
      watch(8, 0, r, f, fr, ff);
      check("mask_fall_ch0", 32'(f), 32'd0);
      check("mask_fall_pending", 32'(bus.pending), 32'h0);

      // Glitch rejection on channel 0
      bus.level[0] = 1'b1;
      step(); step();
      bus.level[0] = 1'b0;
      watch(10, 0, r, f, fr, ff);
      check("glitch2_rises", 32'(r), 32'd0);
      check("glitch2_pending", 32'(bus.pending), 32'h0);
      bus.level[0] = 1'b1;
      step(); step(); step();
      bus.level[0] = 1'b0;
      watch(14, 0, r, f, fr, ff);
      check("pulse3_rises", 32'(r), 32'd1);
      check("pulse3_rise_cycle", 32'(fr), 32'd2);
      check("pulse3_falls_masked", 32'(f), 32'd0);
      check("pulse3_pending", 32'(bus.pending), 32'h1);
      bus.clr = 4'hF;
      step();
      bus.clr = 4'h0;

      // Mode sweep with a 10-cycle square wave on channel 1
      for (int m = 0; m < 4; m++) begin
         bus.mode     = 2'(m);
         bus.level[1] = 1'b1;
         watch(5, 1, r, f, fr, ff);
         bus.level[1] = 1'b0;
         watch(5, 1, r2, f2, fr2, ff2);
         watch(2, 1, r3, f3, fr3, ff3);
         check($sformatf("mode%0d_rises", m), 32'(r + r2 + r3), 32'(exp_rises[m]));
         check($sformatf("mode%0d_falls", m), 32'(f + f2 + f3), 32'(exp_falls[m]));
         if (m == 0) check("mode0_rise_cycle", 32'(fr), 32'd5);
         if (m == 2) check("mode2_fall_cycle", 32'(ff2), 32'd5);
      end
      check("mode_off_no_pending", 32'(bus.pending), 32'h2);

      // FSM keeps tracking while ticks are disabled
      bus.clr = 4'hF;
      step();
      bus.clr = 4'h0;
      bus.level[1] = 1'b1;
      watch(8, 1, r, f, fr, ff);
      check("off_rise_masked", 32'(r), 32'd0);
      check("off_pending", 32'(bus.pending), 32'h0);
      bus.mode = MODE_BOTH;
      watch(4, 1, r, f, fr, ff);
      check("off_track_no_late_rise", 32'(r), 32'd0);
      bus.level[1] = 1'b0;
      watch(8, 1, r, f, fr, ff);
      check("off_track_fall", 32'(f), 32'd1);
      check("off_track_fall_cycle", 32'(ff), 32'd5);
      check("off_track_pending", 32'(bus.pending), 32'h2);
      bus.mode = MODE_RISE;
      bus.clr  = 4'hF;
      step();
      bus.clr  = 4'h0;

      // Pending: set wins over a coincident clear, lone clear drops it
      bus.level[2] = 1'b1;
      watch(4, 2, r, f, fr, ff);
      check("pend_early_rise", 32'(r), 32'd0);
      step();
      check("pend_rise_tick", 32'(bus.rise_tick), 32'h4);
      bus.clr[2] = 1'b1;
      step();
      bus.clr = 4'h0;
      check("pend_set_wins", 32'(bus.pending), 32'h4);
      check("pend_set_wins_irq", 32'(bus.irq), 32'h1);
      step(); step();
      bus.clr = 4'h4;
      step();
      bus.clr = 4'h0;
      check("pend_clr", 32'(bus.pending), 32'h0);
      check("pend_clr_irq", 32'(bus.irq), 32'h0);
      bus.level[2] = 1'b0;
      watch(8, 2, r, f, fr, ff);
      check("pend_fall_masked", 32'(bus.pending), 32'h0);

      // Reset mid-filter discards the partial count
      bus.level[3] = 1'b1;
      step(); step(); step();
      reset_n = 1'b0;
      step();
      check("midrst_rise", 32'(bus.rise_tick), 32'h0);
      check("midrst_pending", 32'(bus.pending), 32'h0);
      reset_n = 1'b1;
      watch(4, 3, r, f, fr, ff);
      check("midrst_no_early_rise", 32'(r), 32'd0);
      step();
      check("midrst_full_latency", 32'(bus.rise_tick), 32'h8);
      step();
      check("midrst_pending_after", 32'(bus.pending), 32'h8);
      check("midrst_irq_after", 32'(bus.irq), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised, multi-channel successor to the single-bit rising-edge Moore detector. Each of `N` asynchronous level inputs is synchronised, glitch-filtered and run through a four-state Moore FSM that emits one-cycle rise/fall ticks, selected by a runtime mode. Ticks also set per-channel sticky pending flags with an aggregate interrupt, so the block sits between raw push-button/sensor pins and the control logic or interrupt controller.

## Interface
- `N`, 4: number of channels, ≥1.
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥1.
- `FILTER_LEN`, 3: consecutive differing samples required to accept a new level, ≥1.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `level`  in  N: raw asynchronous level inputs.
- `mode`  in  2: 00 rising only, 01 falling only, 10 both, 11 disabled. Registered internally as `mode_q`.
- `clr`  in  N: per-channel pending-flag clear, one-cycle pulse.
- `rise_tick`  out  N: one-cycle rising-edge tick per channel.
- `fall_tick`  out  N: one-cycle falling-edge tick per channel.
- `pending`  out  N: sticky "edge seen" flag per channel.
- `irq`  out  1: OR of `pending`.

## Operation
- Per channel, `level[i]` passes through `SYNC_STAGES` flops. The last stage is `s`.
- FSM states: LOW, RISE, HIGH, FALL. Filter counter `cnt` has width max(1, clog2(FILTER_LEN)).
- In LOW, the FSM compares `s` against low:
  - `s`=0: clear `cnt`.
  - `s`=1 and `cnt`==FILTER_LEN-1: go to RISE and clear `cnt`.
  - Otherwise: increment `cnt`.
- In HIGH, the same rule applies with `s`=0 and the target state FALL.
- RISE always goes to HIGH and FALL always goes to LOW after exactly one cycle, with `cnt` cleared. Counting toward the opposite edge starts in the following cycle.
- Unused encodings go to LOW with `cnt` cleared.
- Outputs are Moore, decoded from state and `mode_q` only:
  - `rise_tick[i]` = (state==RISE) & (`mode_q`==00 | `mode_q`==10).
  - `fall_tick[i]` = (state==FALL) & (`mode_q`==01 | `mode_q`==10).
- The FSM always tracks the filtered level, including when mode is 11. Mode only masks the ticks.
- `pending[i]` is set by `rise_tick[i] | fall_tick[i]` and cleared by `clr[i]`. If set and clear occur in the same cycle, set wins.
- Reset (`reset_n`=0 at a `clk` edge) forces:
  - all synchroniser flops to 0;
  - state LOW, `cnt` 0, `mode_q` 00;
  - `pending` 0.
  - Consequently every output is 0 out of reset.
- Reset mid-filter discards the partial count. A channel whose input is high at reset release reports a rise after the full latency.

## Timing
- Latency: `level` changes before edge E0 and stays stable. RISE/FALL is entered at edge E0+SYNC_STAGES+FILTER_LEN-1, and the tick is high for the following cycle. Defaults: the tick is high after the 5th edge, counting E0 as the 1st.
- `pending` rises one cycle after the tick. `irq` has the same timing as `pending`.
- A `mode` write is visible in `mode_q` one cycle later and masks or unmasks ticks from then on.
- A pulse shorter than FILTER_LEN samples of `s` produces no tick and no state change.
- Minimum spacing between opposite ticks on one channel is FILTER_LEN+1 cycles.
- Channels are fully independent. Simultaneous edges on several channels all tick in the same cycle.

## Structure
- Package `edge_det_pkg` holds:
  - state encoding: LOW=2'b00, RISE=2'b01, HIGH=2'b10, FALL=2'b11;
  - mode constants: MODE_RISE, MODE_FALL, MODE_BOTH, MODE_OFF.
- Sub-module `edge_det_channel` contains the synchroniser, filter counter and FSM for one channel. It takes `mode_q` as an input and produces its own rise/fall ticks.
- The top level holds:
  - `mode_q`;
  - a generate loop of `N` `edge_det_channel` instances;
  - the `pending` flags and the `irq` OR.

## Test plan
- Reset and defaults: hold `reset_n`=0 with `level`=4'hF, then release. All outputs stay 0 for 4 cycles. `rise_tick`=4'hF appears in the 5th cycle, and `pending`=4'hF with `irq`=1 one cycle later.
- Glitch rejection: 2-cycle high pulse on `level[0]` with FILTER_LEN=3 gives no tick. A 3-cycle pulse gives exactly one `rise_tick[0]`, then `fall_tick` is masked (mode 00).
- Modes: square wave with 10-cycle period on `level[1]`, stepping mode 00→01→10→11. Per period the bench sees rise only, fall only, both, then none, and FSM state still tracks the input in mode 11.
- Pending: `clr[2]` coincides with `rise_tick[2]`, so `pending[2]` stays 1. A later `clr[2]` alone gives `pending[2]`=0 and `irq`=0.
- Mid-operation reset: `reset_n`=0 during the third filter cycle. The bench checks the count is discarded and the tick appears the full 5 cycles after release.
